// File: rtl/hamming16_pkg.sv
// Shared Hamming(21,16) definitions: widths, pipeline/FSM state types, parity and
// codeword-position helpers used by both the encoder and the decoder.
package hamming16_pkg;

  localparam int DATA_W = 16;
  localparam int PAR_W  = 5;
  localparam int CW_LEN = 21;

  typedef enum logic {EMPTY, FULL} stage_t;
  typedef enum logic {INJ_IDLE, INJ_ARMED} inj_state_t;

  typedef struct packed {
    logic       is_parity;
    logic [3:0] idx;
  } bit_sel_t;

  function automatic logic [PAR_W-1:0] calc_parity(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[11] ^ d[13] ^ d[15];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10] ^ d[12] ^ d[13];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[14] ^ d[15];
    p[3] = ^d[10:4];
    p[4] = ^d[15:11];
    return p;
  endfunction

  // Powers of two are parity slots; data index is position minus the parity slots below it, minus one.
  function automatic bit_sel_t pos_to_bit(input logic [4:0] pos);
    bit_sel_t sel;
    sel.is_parity = 1'b0;
    sel.idx       = '0;
    case (pos)
      5'd1:  begin sel.is_parity = 1'b1; sel.idx = 4'd0; end
      5'd2:  begin sel.is_parity = 1'b1; sel.idx = 4'd1; end
      5'd4:  begin sel.is_parity = 1'b1; sel.idx = 4'd2; end
      5'd8:  begin sel.is_parity = 1'b1; sel.idx = 4'd3; end
      5'd16: begin sel.is_parity = 1'b1; sel.idx = 4'd4; end
      default: begin
        if (pos >= 5'd17)     sel.idx = 4'(pos - 5'd6);
        else if (pos >= 5'd9) sel.idx = 4'(pos - 5'd5);
        else if (pos >= 5'd5) sel.idx = 4'(pos - 5'd4);
        else                  sel.idx = 4'(pos - 5'd3);
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/hamming16_parity.sv
// Combinational Hamming(21,16) parity generator, shared by encoder and decoder.
module hamming16_parity
  import hamming16_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [PAR_W-1:0]  parity
);

  assign parity = calc_parity(data);

endmodule

// File: rtl/hamming16_enc.sv
// Two-stage pipelined Hamming(21,16) encoder with valid/ready handshakes and a delivered-word counter.
// Optional single-bit error injection is built only when HAMMING16_ERR_INJECT_EN is defined.
module hamming16_enc
  import hamming16_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [PAR_W-1:0]   out_parity,
`ifdef HAMMING16_ERR_INJECT_EN
  input  logic               inj_req,
  input  logic [4:0]         inj_pos,
  output logic               inj_ack,
`endif
  output logic [COUNT_W-1:0] word_count
);

  stage_t             s1_state, s2_state;
  logic [DATA_W-1:0]  s1_data, s2_data;
  logic [PAR_W-1:0]   s2_par, par_calc;
  logic [DATA_W-1:0]  data_flip;
  logic [PAR_W-1:0]   par_flip;
  logic               s1_load, s2_load, out_fire;

  assign s2_load   = (s1_state == FULL) && ((s2_state == EMPTY) || out_ready);
  assign in_ready  = (s1_state == EMPTY) || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign out_fire  = (s2_state == FULL) && out_ready;
  assign out_valid = (s2_state == FULL);
  assign out_data  = s2_data;
  assign out_parity = s2_par;

  hamming16_parity u_parity (
    .data   (s1_data),
    .parity (par_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_state <= EMPTY;
      s1_data  <= '0;
    end else if (s1_load) begin
      s1_state <= FULL;
      s1_data  <= in_data;
    end else if (s2_load) begin
      s1_state <= EMPTY;
    end
  end

  // Injection flips land after parity is computed, so the codeword carries a genuine single-bit error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_state <= EMPTY;
      s2_data  <= '0;
      s2_par   <= '0;
    end else if (s2_load) begin
      s2_state <= FULL;
      s2_data  <= s1_data ^ data_flip;
      s2_par   <= par_calc ^ par_flip;
    end else if (out_fire) begin
      s2_state <= EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_count <= '0;
    else if (out_fire) word_count <= word_count + COUNT_W'(1);
  end

`ifdef HAMMING16_ERR_INJECT_EN
  inj_state_t inj_state, inj_state_nxt;
  logic [4:0] inj_pos_q, inj_pos_nxt;
  logic       inj_apply;
  bit_sel_t   inj_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_state <= INJ_IDLE;
      inj_pos_q <= '0;
      inj_ack   <= 1'b0;
    end else begin
      inj_state <= inj_state_nxt;
      inj_pos_q <= inj_pos_nxt;
      inj_ack   <= inj_apply;
    end
  end

  // A new request in the transfer cycle wins the next state, so the old position is consumed and the new one stays armed.
  always_comb begin
    inj_state_nxt = inj_state;
    inj_pos_nxt   = inj_pos_q;
    data_flip     = '0;
    par_flip      = '0;
    inj_sel       = pos_to_bit(inj_pos_q);
    inj_apply     = (inj_state == INJ_ARMED) && s2_load;
    if (inj_apply) begin
      inj_state_nxt = INJ_IDLE;
      if (inj_sel.is_parity) par_flip[inj_sel.idx[2:0]] = 1'b1;
      else                   data_flip[inj_sel.idx]     = 1'b1;
    end
    if (inj_req && (inj_pos >= 5'd1) && (inj_pos <= 5'(CW_LEN))) begin
      inj_state_nxt = INJ_ARMED;
      inj_pos_nxt   = inj_pos;
    end
  end
`else
  assign data_flip = '0;
  assign par_flip  = '0;
`endif

endmodule

// File: tb/tb_hamming16_enc.sv
// Directed self-checking bench for hamming16_enc (narrow counter to reach the wrap quickly).
// Injection scenarios are exercised only when HAMMING16_ERR_INJECT_EN is defined.
module tb_hamming16_enc;
  import hamming16_pkg::*;

  localparam int COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid, out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [PAR_W-1:0]   out_parity;
  logic [COUNT_W-1:0] word_count;
`ifdef HAMMING16_ERR_INJECT_EN
  logic               inj_req, inj_ack;
  logic [4:0]         inj_pos;
  int                 ackSeen = 0;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  // Hand-computed parity for each directed data word.
  logic [DATA_W-1:0] vecData [8] = '{16'h0000, 16'h0001, 16'hFFFF, 16'hA5A5,
                                     16'h1234, 16'h8000, 16'h0400, 16'h00FF};
  logic [PAR_W-1:0]  vecPar  [8] = '{5'b00000, 5'b00011, 5'b11110, 5'b00111,
                                     5'b11001, 5'b10101, 5'b01111, 5'b00011};

  always #5 clk = ~clk;

  hamming16_enc #(.COUNT_W(COUNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
`ifdef HAMMING16_ERR_INJECT_EN
    .inj_req    (inj_req),
    .inj_pos    (inj_pos),
    .inj_ack    (inj_ack),
`endif
    .word_count (word_count)
  );

`ifdef HAMMING16_ERR_INJECT_EN
  always @(negedge clk) if (inj_ack === 1'b1) ackSeen++;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Streams n table words back-to-back with out_ready high; each appears two edges after it is driven.
  task automatic applyStimulus(input int first, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checkOutput("stream_valid", out_valid, 1);
        checkOutput("stream_data", out_data, vecData[(first + i - 2) % 8]);
        checkOutput("stream_parity", out_parity, vecPar[(first + i - 2) % 8]);
      end
      in_valid = (i < n);
      in_data  = vecData[(first + i) % 8];
    end
    @(negedge clk);
    checkOutput("stream_drained", out_valid, 0);
  endtask

`ifdef HAMMING16_ERR_INJECT_EN
  task automatic injectCheck(input logic [4:0] pos, input logic [15:0] expData,
                             input logic [4:0] expPar, input logic expAck);
    @(negedge clk);
    inj_req = 1'b1; inj_pos = pos;
    @(negedge clk);
    inj_req = 1'b0; in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("inj_valid", out_valid, 1);
    checkOutput("inj_data", out_data, expData);
    checkOutput("inj_parity", out_parity, expPar);
    checkOutput("inj_ack_pulse", inj_ack, expAck);
    @(negedge clk);
    checkOutput("inj_ack_cleared", inj_ack, 0);
    checkOutput("inj_drained", out_valid, 0);
  endtask
`endif

  initial begin
    int acksBefore;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef HAMMING16_ERR_INJECT_EN
    inj_req = 1'b0; inj_pos = '0;
`endif
    acksBefore = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_parity", out_parity, 0);
    checkOutput("rst_word_count", word_count, 0);
    rst_n = 1'b1;

    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_count_hold", word_count, 0);
    checkOutput("idle_out_valid", out_valid, 0);

    applyStimulus(0, 3);
    checkOutput("count_after_three", word_count, 3);

    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = vecData[3]; #1 checkOutput("bp_ready_w0", in_ready, 1);
    @(negedge clk); in_data = vecData[4]; #1 checkOutput("bp_ready_w1", in_ready, 1);
    @(negedge clk); in_data = vecData[5]; #1 checkOutput("bp_ready_full", in_ready, 0);
    checkOutput("bp_hold_valid", out_valid, 1);
    checkOutput("bp_hold_data", out_data, vecData[3]);
    @(negedge clk);
    checkOutput("bp_still_full", in_ready, 0);
    checkOutput("bp_stable_data", out_data, vecData[3]);
    checkOutput("bp_stable_parity", out_parity, vecPar[3]);
    out_ready = 1'b1; #1 checkOutput("bp_release_ready", in_ready, 1);
    @(negedge clk);
    checkOutput("bp_out_w1", out_data, vecData[4]);
    in_data = vecData[6]; #1 checkOutput("bp_ready_w3", in_ready, 1);
    @(negedge clk);
    checkOutput("bp_out_w2", out_data, vecData[5]);
    checkOutput("bp_par_w2", out_parity, vecPar[5]);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_out_w3", out_data, vecData[6]);
    checkOutput("bp_par_w3", out_parity, vecPar[6]);
    @(negedge clk);
    checkOutput("bp_drained", out_valid, 0);
    checkOutput("bp_count", word_count, 7);

    applyStimulus(0, 8);
    checkOutput("count_all_ones", word_count, 15);
    applyStimulus(1, 1);
    checkOutput("count_wrapped", word_count, 0);

`ifdef HAMMING16_ERR_INJECT_EN
    injectCheck(5'd3, 16'h0001, 5'b00000, 1'b1);
    injectCheck(5'd16, 16'h0000, 5'b10000, 1'b1);
    injectCheck(5'd0, 16'h0000, 5'b00000, 1'b0);
`endif

    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = vecData[3];
    @(negedge clk); in_data = vecData[4];
    @(negedge clk); in_valid = 1'b0;
    checkOutput("prerst_full", in_ready, 0);
`ifdef HAMMING16_ERR_INJECT_EN
    inj_req = 1'b1; inj_pos = 5'd5;
    @(negedge clk); inj_req = 1'b0;
    acksBefore = ackSeen;
`endif
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out_data", out_data, 0);
    checkOutput("midrst_out_parity", out_parity, 0);
    checkOutput("midrst_count", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3, 1);
    checkOutput("postrst_count", word_count, 1);
`ifdef HAMMING16_ERR_INJECT_EN
    checkOutput("postrst_no_ack", ackSeen, acksBefore);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/hamming16_enc.md
# hamming16_enc

Pipelined Hamming(21,16) encoder producing the 16 data bits plus 5 parity bits consumed by `hamming16` on the read side. It sits on the write path in front of the protected ROM/memory image. Data streams in and codewords stream out over valid/ready handshakes. A wrapping counter tracks delivered codewords, and an optional error-injection port corrupts a single chosen codeword bit to exercise the decoder.

## Interface
- `COUNT_W`, default 16: width of `word_count`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  encoder accepts `in_data` this cycle.
- `in_data`  in  16  data word.
- `out_valid`  out  1  codeword is valid.
- `out_ready`  in  1  downstream accepts the codeword.
- `out_data`  out  16  data bits; maps to the decoder's `d_in`.
- `out_parity`  out  5  parity bits; maps to the decoder's `p_in`.
- `word_count`  out  COUNT_W  number of codewords delivered, modulo 2^COUNT_W.
- `inj_req`  in  1  arm a single-bit error. Present only with the macro.
- `inj_pos`  in  5  codeword position to flip, 1..21. Present only with the macro.
- `inj_ack`  out  1  one-cycle pulse when the flip has been applied. Present only with the macro.

## Operation
- Parity equations, with `d` = data:
  - p[0] = d0^d1^d3^d4^d6^d8^d10^d11^d13^d15
  - p[1] = d0^d2^d3^d5^d6^d9^d10^d12^d13
  - p[2] = d1^d2^d3^d7^d8^d9^d10^d14^d15
  - p[3] = ^d[10:4]
  - p[4] = ^d[15:11]
- Codeword positions, 1-based:
  - Positions 1, 2, 4, 8, 16 hold p[0..4].
  - Position 3 holds d0; 5–7 hold d1–d3; 9–15 hold d4–d10; 17–21 hold d11–d15.
- Two register stages:
  - S1 captures `in_data`.
  - S2 holds data plus computed parity.
  - Each stage has a valid bit; per stage the state is EMPTY or FULL.
- S2 loads from S1 when S1 is FULL and (S2 is EMPTY or `out_ready` is high).
- S1 loads from input when `in_valid` and `in_ready` are both high.
- `in_ready` = S1 EMPTY, or S1 moving to S2 this cycle. This is combinational through `out_ready`.
- `out_valid` = S2 FULL. `out_data` and `out_parity` stay stable while `out_valid` is high and `out_ready` is low.
- `word_count` increments on each out handshake and wraps from all-ones to 0.
- Injection FSM, states IDLE and ARMED:
  - `inj_req` with `inj_pos` in 1..21 latches the position and moves to ARMED.
  - `inj_req` with position 0 or 22..31 is ignored.
  - `inj_req` while ARMED overwrites the latched position.
  - In ARMED, the next S1-to-S2 transfer XORs the bit at the latched position into the S2 codeword (after parity calculation), pulses `inj_ack`, and returns to IDLE.
  - If `inj_req` and the transfer occur in the same cycle, the old position is applied and the FSM stays ARMED with the new position.

## Timing
- Reset values: both stages EMPTY, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_parity`=0, `word_count`=0, FSM IDLE, `inj_ack`=0.
- Latency: a word accepted at edge N is presented with `out_valid` high after edge N+1.
- Throughput: 1 word/cycle with `out_ready` held high.
- Full backpressure: both stages FULL, `in_ready`=0. The pipeline restarts the cycle `out_ready` rises, with no bubble and no loss.
- Reset mid-operation: contents are discarded and any armed injection is cancelled. No `inj_ack` is issued.
- Empty pipeline: `out_ready` has no effect and `word_count` holds.

## Configuration
- `HAMMING16_ERR_INJECT_EN`:
  - Defined: the injection ports and FSM exist.
  - Undefined: the ports are absent, the FSM is removed, and every codeword is exact.

## Structure
- `hamming16_pkg` holds:
  - `DATA_W`=16, `PAR_W`=5, `CW_LEN`=21.
  - Function `calc_parity(data) -> [4:0]`.
  - Function `pos_to_bit(pos)`, returning a parity/data select and an index. The decoder uses the same position mapping.
- Sub-module `hamming16_parity`: combinational parity generator, shared with the decoder.

## Test plan
- Send 16'h0000, 16'h0001, 16'hFFFF back-to-back with `out_ready`=1 → parity 5'b00000, 5'b00011, 5'b11110 on three consecutive cycles; `word_count`=3.
- Hold `out_ready`=0 and offer 4 words → two accepted, `in_ready`=0. Release `out_ready` → all 4 delivered in order with no duplicates.
- With the macro, send 16'h0000 with `inj_pos`=3 → `out_data`=16'h0001, `out_parity`=0, one `inj_ack`. A decoder fed this codeword restores 16'h0000.
- With the macro, send 16'h0000 with `inj_pos`=16 → `out_parity`=5'b10000. With `inj_pos`=0 → no flip and no `inj_ack`.
- Assert `rst_n` low while both stages are FULL and injection is ARMED → all outputs take their reset values and the next word is encoded exactly.
- Force `word_count` to all-ones with `COUNT_W`=4 (15 words), then deliver one more → `word_count`=0.
